sdram_arbiter: RTL and testbench

Two-requester arbiter that shares the single SDRAM controller port between the CPU cache and a second bus master (DMA/video fetch). Each requester sees the same request/fill interface the cache already uses: 4-word burst reads and single-word writes. The arbiter grants one requester at a time with round-robin priority, forwards its address, direction and write data to the controller, and routes the controller's fill and ack strobes back to the granted requester only.

---
 rtl/sdram_arbiter.sv | 94 +++++++++
 tb/tb_sdram_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between two requesters.
// One transaction is in flight at a time: either a BURST_LEN-word read burst or a single write.
module sdram_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        fill0,
  output logic        fill1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_fill,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t          state, state_nxt;
  logic            grant, last;
  logic [CW-1:0]   cnt;
  logic            do_grant, sel;
  logic            busy;

  assign busy = (state == BUSY);

  // On a tie the port that did not win last time gets the controller.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    sel       = 1'b0;
    case (state)
      IDLE: if (req0 | req1) begin
        do_grant  = 1'b1;
        sel       = (req0 & req1) ? ~last : req1;
        state_nxt = BUSY;
      end
      BUSY: if (mem_rw ? (mem_fill && cnt == CW'(BURST_LEN - 1)) : mem_ack)
        state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_rw    <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        grant     <= sel;
        last      <= sel;
        cnt       <= '0;
        mem_req   <= 1'b1;
        mem_rw    <= sel ? rw1    : rw0;
        mem_addr  <= sel ? addr1  : addr0;
        mem_wdata <= sel ? wdata1 : wdata0;
      end else if (busy) begin
        // Controller only looks at req when starting, so drop it on the first strobe.
        if (mem_fill | mem_ack) mem_req <= 1'b0;
        if (mem_fill && mem_rw) cnt <= cnt + 1'b1;
      end
    end
  end

  assign fill0 = mem_fill & busy & ~grant;
  assign fill1 = mem_fill & busy &  grant;
  assign ack0  = mem_ack  & busy & ~grant;
  assign ack1  = mem_ack  & busy &  grant;
  assign rdata = mem_rdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reads, writes, round-robin ties, reset mid-burst, stray strobes.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, rw0, rw1;
  logic [31:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        fill0, fill1, ack0, ack1;
  logic [15:0] rdata;
  logic        mem_req, mem_rw;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_fill, mem_ack;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic p;

  sdram_arbiter #(.BURST_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .fill0(fill0), .fill1(fill1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_fill(mem_fill), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; rw0 = 1; rw1 = 1;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_fill = 0; mem_ack = 0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_rw", mem_rw, 1'b1);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_strobes", {fill0, fill1, ack0, ack1}, 4'b0000);
    reset = 1'b0;
    tick();

    // Single read on port 0, controller answers after 3 cycles
    req0 = 1; rw0 = 1; addr0 = 32'h0000_1238;
    tick();
    chk("rd_req_c1", mem_req, 1'b1);
    chk("rd_addr", mem_addr, 32'h0000_1238);
    chk("rd_rw", mem_rw, 1'b1);
    tick(); chk("rd_req_c2", mem_req, 1'b1);
    tick(); chk("rd_req_c3", mem_req, 1'b1);
    for (int i = 0; i < 4; i++) begin
      mem_fill = 1; mem_rdata = 16'hA000 + 16'(i);
      #1;
      chk("rd_fill0", fill0, 1'b1);
      chk("rd_fill1", fill1, 1'b0);
      chk("rd_rdata", rdata, 32'hA000 + i);
      tick();
      req0 = 0;
      chk("rd_req_low", mem_req, 1'b0);
    end
    mem_fill = 0;

    // Write on port 1 raised during RELEASE: granted only after IDLE
    req1 = 1; rw1 = 0; addr1 = 32'h40; wdata1 = 16'hBEEF;
    tick();
    chk("wr_release_noreq", mem_req, 1'b0);
    chk("wr_addr_held", mem_addr, 32'h0000_1238);
    tick();
    chk("wr_req", mem_req, 1'b1);
    chk("wr_rw", mem_rw, 1'b0);
    chk("wr_addr", mem_addr, 32'h40);
    chk("wr_wdata", mem_wdata, 16'hBEEF);
    mem_ack = 1;
    #1;
    chk("wr_ack1", ack1, 1'b1);
    chk("wr_ack0", ack0, 1'b0);
    tick();
    mem_ack = 0; req1 = 0;
    #1;
    chk("wr_req_low", mem_req, 1'b0);
    chk("wr_ack1_pulse", ack1, 1'b0);
    tick();

    // Contention after reset: grants alternate 0,1,0,1
    reset = 1;
    tick();
    reset = 0; req0 = 1; req1 = 1; rw0 = 1; rw1 = 1;
    addr0 = 32'h100; addr1 = 32'h200;
    for (int g = 0; g < 4; g++) begin
      p = g[0];
      tick();
      chk("ct_req", mem_req, 1'b1);
      chk("ct_addr", mem_addr, p ? 32'h200 : 32'h100);
      for (int i = 0; i < 4; i++) begin
        mem_fill = 1; mem_rdata = 16'hC000 + 16'(i);
        #1;
        chk("ct_fill0", fill0, !p);
        chk("ct_fill1", fill1, p);
        tick();
      end
      mem_fill = 0;
      tick();
    end

    // New port-1 request mid-way through a port-0 burst
    req1 = 0; addr0 = 32'h300;
    tick();
    chk("mb_addr0", mem_addr, 32'h300);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin req1 = 1; addr1 = 32'h400; rw1 = 1; end
      mem_fill = 1;
      #1;
      chk("mb_fill0", fill0, 1'b1);
      tick();
      chk("mb_addr_held", mem_addr, 32'h300);
    end
    mem_fill = 0; req0 = 0;
    tick();
    chk("mb_idle_noreq", mem_req, 1'b0);
    chk("mb_idle_addr", mem_addr, 32'h300);
    tick();
    chk("mb_grant1_req", mem_req, 1'b1);
    chk("mb_grant1_addr", mem_addr, 32'h400);
    for (int i = 0; i < 4; i++) begin
      mem_fill = 1;
      #1;
      chk("mb_fill1", fill1, 1'b1);
      chk("mb_fill0_off", fill0, 1'b0);
      tick();
      req1 = 0;
    end
    mem_fill = 0;
    tick(); tick();

    // Reset after the 2nd fill of a port-0 read
    req0 = 1; addr0 = 32'h500; rw0 = 1;
    tick();
    chk("rs_req", mem_req, 1'b1);
    mem_fill = 1;
    tick();
    reset = 1; req0 = 0;
    tick();
    reset = 0;
    #1;
    chk("rs_req_low", mem_req, 1'b0);
    chk("rs_addr_rst", mem_addr, 32'h0);
    chk("rs_fill0_f3", fill0, 1'b0);
    tick();
    chk("rs_fill0_f4", fill0, 1'b0);
    chk("rs_fill1_f4", fill1, 1'b0);
    tick();
    mem_fill = 0;
    req0 = 1; req1 = 1; addr1 = 32'h600;
    tick();
    chk("rs_tie_req", mem_req, 1'b1);
    chk("rs_tie_port0", mem_addr, 32'h500);

    // Stray strobes while IDLE
    reset = 1; req0 = 0; req1 = 0;
    tick();
    reset = 0;
    tick();
    mem_fill = 1; mem_ack = 1;
    #1;
    chk("st_strobes", {fill0, fill1, ack0, ack1}, 4'b0000);
    tick();
    chk("st_strobes2", {fill0, fill1, ack0, ack1}, 4'b0000);
    chk("st_noreq", mem_req, 1'b0);
    mem_fill = 0; mem_ack = 0;
    req1 = 1; rw1 = 0; addr1 = 32'h80; wdata1 = 16'h1234;
    tick();
    chk("st_grant_req", mem_req, 1'b1);
    chk("st_grant_addr", mem_addr, 32'h80);
    mem_ack = 1;
    #1;
    chk("st_ack1", ack1, 1'b1);
    tick();
    mem_ack = 0; req1 = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
